filter_stream_fetch: RTL and testbench
======================================

Name: filter_stream_fetch

Overview:
Consumes the per-filter stream request issued by the PE controller (valid, conv layer, filter index k) and streams that filter's compressed weights (non-zero value + zero-run index) from the weight SRAM into the PE multiplier front-end. Sits directly downstream of the PE controller and upstream of the PE's weight operand buffer. It prefetches through a small FIFO so the PE sees one weight per cycle when it is ready.

Parameters:
DATA_W, 8, weight value width
IDX_W, 4, zero-run index width
ADDR_W, 12, weight SRAM address width
LEN_W, 8, non-zero count width per filter
LAYER_W, 2, conv layer number width
K_W, 4, filter index width
FIFO_DEPTH, 4, prefetch FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  stream request valid (from PE controller)
req_ready  out  1  block idle, request accepted this cycle when req_valid & req_ready
req_layer  in  LAYER_W  conv layer of request
req_k  in  K_W  filter index of request
req_base_addr  in  ADDR_W  SRAM address of first compressed weight
req_len  in  LEN_W  number of non-zero weights
mem_rd_en  out  1  SRAM read strobe
mem_rd_addr  out  ADDR_W  SRAM read address
mem_rd_data  in  DATA_W+IDX_W  {value, idx}, valid exactly 1 cycle after mem_rd_en
out_valid  out  1  weight available
out_ready  in  1  PE accepts weight
out_value  out  DATA_W  weight value
out_idx  out  IDX_W  zero-run index
out_last  out  1  final weight of current filter
out_layer  out  LAYER_W  layer tag of current filter
out_k  out  K_W  filter tag of current filter
done  out  1  one-cycle pulse: filter fully delivered

Behaviour:
- Reset (async, active-high): state=IDLE; req_ready=1; mem_rd_en=0; out_valid=0; out_last=0; done=0; FIFO empty; counters, tags and address = 0. Reset mid-operation aborts the transfer; the in-flight SRAM read is discarded.
- FSM IDLE -> FETCH on accepted request with req_len!=0; latch layer, k, base address, issue_cnt=req_len, deliver_cnt=req_len.
- Accepted request with req_len==0: no SRAM reads, no output; done pulses the cycle after acceptance; stay IDLE.
- FETCH: mem_rd_en=1 when issue_cnt!=0 and (fifo_count + inflight) < FIFO_DEPTH; inflight is 1 if mem_rd_en was high last cycle, else 0. Each read increments address and decrements issue_cnt. Address wraps modulo 2^ADDR_W.
- Write FIFO with mem_rd_data on the cycle after each mem_rd_en. Credit rule guarantees no overflow. A write to a full FIFO is a design error (assert).
- Output = FIFO head: out_valid = !empty. Pop on out_valid & out_ready, decrement deliver_cnt. out_last=1 when out_valid and deliver_cnt==1. Simultaneous push and pop in the same cycle keeps occupancy unchanged.
- Outputs hold stable while out_valid & !out_ready.
- FETCH -> IDLE when the pop with out_last happens. done pulses the following cycle. req_ready returns to 1 in that same cycle. No new request is accepted while in FETCH (req_ready=0).
- Latency: first out_valid 2 cycles after request acceptance. With out_ready held high, throughput is 1 weight/cycle after fill.
- out_layer/out_k hold the latched tags during FETCH. Tags are retained after completion until the next accept.

Decomposition:
- Shared package: weight-entry struct {value, idx}, stream-request struct {valid, layer, k, base_addr, len}, and the width constants. The PE controller reuses the stream-request struct.
- One sub-module: filter_fetch_fifo, a synchronous FIFO (depth FIFO_DEPTH, async active-high reset) exposing count, full and empty.

Test Plan:
- Request layer=1, k=3, base=0x010, len=5, out_ready=1; SRAM returns addr-derived data -> 5 beats on consecutive cycles, first out_valid 2 cycles after accept, out_last on beat 5, out_layer=1, out_k=3, done 1 cycle later.
- len=0 request -> no mem_rd_en, no out_valid; done pulses 1 cycle after accept; req_ready stays 1.
- len=10 with out_ready held low 8 cycles -> exactly FIFO_DEPTH(4) reads issued, then mem_rd_en=0, no FIFO overflow. On release, all 10 weights arrive in address order.
- base=0xFFE, len=4 -> read addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Random out_ready toggling over len=32 -> delivered sequence equals SRAM contents, no drops or duplicates, and out_value/out_idx are stable while stalled.
- rst asserted mid-transfer (after 3 beats of len=8) -> outputs clear immediately. A new request after deassertion (k=7, len=2) delivers only 2 fresh beats.

Source files
------------

// File: rtl/filter_stream_fetch_pkg.sv
// Shared types and widths for the per-filter compressed-weight streaming path.
// The PE controller reuses stream_req_t when it builds requests.
package filter_stream_fetch_pkg;

    localparam int DATA_W     = 8;
    localparam int IDX_W      = 4;
    localparam int ADDR_W     = 12;
    localparam int LEN_W      = 8;
    localparam int LAYER_W    = 2;
    localparam int K_W        = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic [IDX_W-1:0]  idx;
    } weight_entry_t;

    typedef struct packed {
        logic               valid;
        logic [LAYER_W-1:0] layer;
        logic [K_W-1:0]     k;
        logic [ADDR_W-1:0]  base_addr;
        logic [LEN_W-1:0]   len;
    } stream_req_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/filter_stream_fetch_if.sv
// Signal bundle between the PE controller, weight SRAM, PE front-end and the fetch block.
// The fetch block takes the slave modport; the surrounding system takes master.
interface filter_stream_fetch_if;
    import filter_stream_fetch_pkg::*;

    // Handshakes: a request transfers on a clock edge where req_valid & req_ready are both high,
    // a weight transfers on an edge where out_valid & out_ready are both high; once raised,
    // out_valid and its payload hold until that transfer happens.
    logic               req_valid;
    logic               req_ready;
    logic [LAYER_W-1:0] req_layer;
    logic [K_W-1:0]     req_k;
    logic [ADDR_W-1:0]  req_base_addr;
    logic [LEN_W-1:0]   req_len;

    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_rd_addr;
    weight_entry_t      mem_rd_data;

    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_value;
    logic [IDX_W-1:0]   out_idx;
    logic               out_last;
    logic [LAYER_W-1:0] out_layer;
    logic [K_W-1:0]     out_k;
    logic               done;

    fetch_state_t       dbg_state;

    modport master (
        output req_valid, req_layer, req_k, req_base_addr, req_len, mem_rd_data, out_ready,
        input  req_ready, mem_rd_en, mem_rd_addr, out_valid, out_value, out_idx, out_last,
               out_layer, out_k, done, dbg_state
    );

    modport slave (
        input  req_valid, req_layer, req_k, req_base_addr, req_len, mem_rd_data, out_ready,
        output req_ready, mem_rd_en, mem_rd_addr, out_valid, out_value, out_idx, out_last,
               out_layer, out_k, done, dbg_state
    );

endinterface

// File: rtl/filter_fetch_fifo.sv
// Prefetch FIFO for compressed weights; head entry is presented combinationally.
module filter_fetch_fifo
    import filter_stream_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  weight_entry_t   push_data,
    input  logic            pop,
    output weight_entry_t   pop_data,
    output logic [CNT_W-1:0] count,
    output logic            full,
    output logic            empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    weight_entry_t    mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign count    = count_q;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            // Push and pop together leave occupancy unchanged.
            case ({push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/filter_stream_fetch.sv
// Streams one filter's compressed weights from the weight SRAM into the PE front-end,
// prefetching through a small FIFO with read credits so it never overflows.
module filter_stream_fetch
    import filter_stream_fetch_pkg::*;
(
    input logic                  clk,
    input logic                  rst,
    filter_stream_fetch_if.slave bus
);
    fetch_state_t       state_q, state_d;
    stream_req_t        req;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   issue_cnt_q;
    logic [LEN_W-1:0]   deliver_cnt_q;
    logic [LAYER_W-1:0] layer_q;
    logic [K_W-1:0]     k_q;
    logic               inflight_q;
    logic               done_q;

    logic               accept;
    logic               rd_en;
    logic               pop;
    logic               last_beat;
    logic [CNT_W:0]     credit_used;
    weight_entry_t      head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;

    assign req = '{valid: bus.req_valid, layer: bus.req_layer, k: bus.req_k,
                   base_addr: bus.req_base_addr, len: bus.req_len};

    assign accept      = req.valid && (state_q == ST_IDLE);
    // A read still in flight already owns a FIFO slot.
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign rd_en       = (state_q == ST_FETCH) && (issue_cnt_q != '0)
                         && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign pop         = !fifo_empty && bus.out_ready;
    assign last_beat   = !fifo_empty && (deliver_cnt_q == LEN_W'(1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept && (req.len != '0)) state_d = ST_FETCH;
            ST_FETCH: if (pop && last_beat)          state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            issue_cnt_q   <= '0;
            deliver_cnt_q <= '0;
            layer_q       <= '0;
            k_q           <= '0;
            inflight_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rd_en;
            done_q     <= (accept && (req.len == '0)) || (pop && last_beat);
            if (accept) begin
                layer_q       <= req.layer;
                k_q           <= req.k;
                addr_q        <= req.base_addr;
                issue_cnt_q   <= req.len;
                deliver_cnt_q <= req.len;
            end else begin
                if (rd_en) begin
                    addr_q      <= addr_q + ADDR_W'(1);
                    issue_cnt_q <= issue_cnt_q - LEN_W'(1);
                end
                if (pop) deliver_cnt_q <= deliver_cnt_q - LEN_W'(1);
            end
        end
    end

    filter_fetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (bus.mem_rd_data),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(inflight_q && fifo_full && !pop));

    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_rd_addr = addr_q;
    assign bus.out_valid   = !fifo_empty;
    assign bus.out_value   = head.value;
    assign bus.out_idx     = head.idx;
    assign bus.out_last    = last_beat;
    assign bus.out_layer   = layer_q;
    assign bus.out_k       = k_q;
    assign bus.done        = done_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_filter_stream_fetch.sv
// Bench for filter_stream_fetch: SRAM model, request driver, negedge monitor with
// expected-weight and expected-address queues, vector table and corner sequences.
module tb_filter_stream_fetch;
    import filter_stream_fetch_pkg::*;

    localparam int EW = DATA_W + IDX_W;

    typedef struct {
        logic [LAYER_W-1:0] layer;
        logic [K_W-1:0]     k;
        logic [ADDR_W-1:0]  base;
        logic [LEN_W-1:0]   len;
        int                 exp_first;
        int                 exp_done;
        int                 exp_reads;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    filter_stream_fetch_if bus();
    filter_stream_fetch dut (.clk(clk), .rst(rst), .bus(bus));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [EW-1:0] sram [1 << ADDR_W];
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= sram[bus.mem_rd_addr];
    end

    int n_checks = 0;
    int n_pass = 0;
    logic [EW-1:0]      exp_q[$];
    logic [ADDR_W-1:0]  addr_exp_q[$];
    logic [LAYER_W-1:0] exp_layer;
    logic [K_W-1:0]     exp_k;
    int accept_cyc = 0;
    int first_valid_cyc, done_cyc, reads, beats, dones;
    logic stall_prev = 1'b0;
    logic [EW+1:0] prev_out;

    function automatic void check(string name, logic [31:0] actual, logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    endfunction

    // Monitor: every read address, every delivered beat, stall stability and done pulses.
    always @(negedge clk) begin
        logic [EW-1:0] exp_w;
        logic [ADDR_W-1:0] exp_a;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (bus.mem_rd_en) begin
                reads++;
                check("rd_pending", 32'(addr_exp_q.size() > 0), 1);
                if (addr_exp_q.size() > 0) begin
                    exp_a = addr_exp_q.pop_front();
                    check("rd_addr", bus.mem_rd_addr, exp_a);
                end
            end
            if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc - accept_cyc;
            if (stall_prev)
                check("stall_stable", {bus.out_valid, bus.out_last, bus.out_value, bus.out_idx}, prev_out);
            if (bus.out_valid && bus.out_ready) begin
                beats++;
                check("beat_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_w = exp_q.pop_front();
                    check("beat_data", {bus.out_value, bus.out_idx}, exp_w);
                    check("beat_last", bus.out_last, 32'(exp_q.size() == 0));
                    check("beat_tag", {bus.out_layer, bus.out_k}, {exp_layer, exp_k});
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.out_valid, bus.out_last, bus.out_value, bus.out_idx};
            if (bus.done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc - accept_cyc;
            end
        end
    end

    task automatic clear_stats();
        first_valid_cyc = -1;
        done_cyc = -1;
        reads = 0;
        beats = 0;
        dones = 0;
    endtask

    task automatic send_req(input logic [LAYER_W-1:0] layer, input logic [K_W-1:0] k,
                            input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
        int waited = 0;
        @(negedge clk);
        while (!bus.req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("req_ready_wait", bus.req_ready, 1);
        exp_layer = layer;
        exp_k = k;
        for (int i = 0; i < int'(len); i++) begin
            addr_exp_q.push_back(ADDR_W'((int'(base) + i) % (1 << ADDR_W)));
            exp_q.push_back(sram[(int'(base) + i) % (1 << ADDR_W)]);
        end
        bus.req_valid = 1'b1;
        bus.req_layer = layer;
        bus.req_k = k;
        bus.req_base_addr = base;
        bus.req_len = len;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (dones == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(dones != 0), 1);
    endtask

    task automatic run_vec(input vec_t v);
        clear_stats();
        bus.out_ready = 1'b1;
        send_req(v.layer, v.k, v.base, v.len);
        wait_done(100);
        repeat (3) @(negedge clk);
        check("first_lat", first_valid_cyc, v.exp_first);
        check("done_lat", done_cyc, v.exp_done);
        check("reads", reads, v.exp_reads);
        check("beats", beats, 32'(v.len));
        check("done_once", dones, 1);
        check("exp_drained", exp_q.size(), 0);
        check("req_ready_idle", bus.req_ready, 1);
    endtask

    task automatic run_random(input logic [LEN_W-1:0] len);
        int n = 0;
        clear_stats();
        send_req(LAYER_W'($urandom), K_W'($urandom), ADDR_W'($urandom), len);
        while (dones == 0 && n < 400) begin
            @(posedge clk);
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        check("rand_done_seen", 32'(dones != 0), 1);
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rand_beats", beats, 32'(len));
        check("rand_reads", reads, 32'(len));
        check("rand_drained", exp_q.size(), 0);
    endtask

    initial begin
        vec_t vecs[4];
        int n;
        vecs[0] = '{layer: 2'd1, k: 4'd3,  base: 12'h010, len: 8'd5, exp_first: 2,  exp_done: 7, exp_reads: 5};
        vecs[1] = '{layer: 2'd0, k: 4'd0,  base: 12'h123, len: 8'd0, exp_first: -1, exp_done: 0, exp_reads: 0};
        vecs[2] = '{layer: 2'd2, k: 4'd9,  base: 12'hFFE, len: 8'd4, exp_first: 2,  exp_done: 6, exp_reads: 4};
        vecs[3] = '{layer: 2'd3, k: 4'd15, base: 12'h7F0, len: 8'd1, exp_first: 2,  exp_done: 3, exp_reads: 1};

        for (int i = 0; i < (1 << ADDR_W); i++) sram[i] = EW'($urandom);
        bus.req_valid = 1'b0;
        bus.req_layer = '0;
        bus.req_k = '0;
        bus.req_base_addr = '0;
        bus.req_len = '0;
        bus.out_ready = 1'b0;
        clear_stats();

        repeat (3) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_rd_en", bus.mem_rd_en, 0);
        check("rst_rd_addr", bus.mem_rd_addr, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_done", bus.done, 0);
        check("rst_tags", {bus.out_layer, bus.out_k}, 0);
        check("rst_state", bus.dbg_state, ST_IDLE);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Long filter with the PE stalled: reads must stop once the FIFO credits run out.
        clear_stats();
        bus.out_ready = 1'b0;
        send_req(2'd2, 4'd5, 12'h200, 8'd10);
        repeat (8) @(negedge clk);
        check("stall_reads", reads, FIFO_DEPTH);
        check("stall_rd_en", bus.mem_rd_en, 0);
        check("stall_valid", bus.out_valid, 1);
        check("stall_state", bus.dbg_state, ST_FETCH);
        check("stall_req_ready", bus.req_ready, 0);
        bus.out_ready = 1'b1;
        wait_done(100);
        repeat (2) @(negedge clk);
        check("stall_beats", beats, 10);
        check("stall_total_reads", reads, 10);
        check("stall_drained", exp_q.size(), 0);

        run_random(8'd32);
        for (int i = 0; i < 3; i++) run_random(LEN_W'($urandom_range(1, 24)));

        // Reset in the middle of a transfer, then a fresh short filter.
        clear_stats();
        bus.out_ready = 1'b1;
        send_req(2'd1, 4'd4, 12'h300, 8'd8);
        n = 0;
        while (n < 3 && cyc - accept_cyc < 50) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) n++;
        end
        check("pre_rst_beats", n, 3);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_last", bus.out_last, 0);
        check("mid_rst_rd_en", bus.mem_rd_en, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_ready", bus.req_ready, 1);
        check("mid_rst_tags", {bus.out_layer, bus.out_k}, 0);
        exp_q.delete();
        addr_exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_stats();
        send_req(2'd0, 4'd7, 12'h340, 8'd2);
        wait_done(50);
        repeat (3) @(negedge clk);
        check("post_rst_beats", beats, 2);
        check("post_rst_reads", reads, 2);
        check("post_rst_drained", exp_q.size(), 0);
        check("post_rst_done_once", dones, 1);
        check("post_rst_k", bus.out_k, 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
